// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding selects
// and the long-multiply sequencing states.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE,
        LONG_HI
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: register-match and stage-control
// inputs, forwarding/stall/flush outputs and the stall performance count.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             Match_1E_M;
    logic             Match_1E_W;
    logic             Match_2E_M;
    logic             Match_2E_W;
    logic             Match_12D_E;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             LongE;
    logic             BranchTakenE;
    logic             PCWrPendingF;
    logic             PCSrcW;

    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             LongPhaseE;
    logic [CNT_W-1:0] StallCount;

    // Datapath side
    modport master (
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        output RegWriteM, RegWriteW, MemtoRegE, LongE, BranchTakenE,
        output PCWrPendingF, PCSrcW,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
        input  LongPhaseE, StallCount
    );

    // Hazard controller side
    modport slave (
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        input  RegWriteM, RegWriteW, MemtoRegE, LongE, BranchTakenE,
        input  PCWrPendingF, PCSrcW,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
        output LongPhaseE, StallCount
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage ARM pipeline: forwarding selects,
// load-use and long-multiply stalls, branch/PC flushes and a stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hz
);

    hz_state_e        state_q, state_d;
    logic             ldrstall;
    logic             longstall;
    logic             stall_d;
    logic [CNT_W-1:0] stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A taken branch squashes the long op, so its hi-word phase never starts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hz.LongE && !hz.BranchTakenE) state_d = LONG_HI;
            LONG_HI: state_d = IDLE;
        endcase
    end

    always_comb begin
        ldrstall  = hz.Match_12D_E & hz.MemtoRegE;
        longstall = (state_q == IDLE) & hz.LongE & ~hz.BranchTakenE;

        hz.ForwardAE = FWD_RF;
        if (hz.Match_1E_M && hz.RegWriteM) begin
            hz.ForwardAE = FWD_MEM;
        end else if (hz.Match_1E_W && hz.RegWriteW) begin
            hz.ForwardAE = FWD_WB;
        end

        hz.ForwardBE = FWD_RF;
        if (hz.Match_2E_M && hz.RegWriteM) begin
            hz.ForwardBE = FWD_MEM;
        end else if (hz.Match_2E_W && hz.RegWriteW) begin
            hz.ForwardBE = FWD_WB;
        end

        hz.StallF     = ldrstall | hz.PCWrPendingF | longstall;
        hz.StallD     = ldrstall | longstall;
        hz.StallE     = longstall;
        hz.FlushD     = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
        // The held long op must not be cleared while it waits for its hi word.
        hz.FlushE     = (ldrstall | hz.BranchTakenE) & ~longstall;
        hz.LongPhaseE = (state_q == LONG_HI);

        if (reset) begin
            hz.ForwardAE  = FWD_RF;
            hz.ForwardBE  = FWD_RF;
            hz.StallF     = 1'b0;
            hz.StallD     = 1'b0;
            hz.StallE     = 1'b0;
            hz.FlushD     = 1'b1;
            hz.FlushE     = 1'b1;
            hz.LongPhaseE = 1'b0;
        end
    end

    assign stall_d = hz.StallD;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .clr_i   (reset),
        .inc_i   (stall_d),
        .count_o (stall_count)
    );

    assign hz.StallCount = stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (16-bit and 3-bit counters)
// share stimulus and are checked every cycle against a behavioural model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic m1em, m1ew, m2em, m2ew, m12de, rwm, rww, mtr, lng, br, pcw, pcsw;

    int checks   = 0;
    int failures = 0;

    // Model state: whether the previous cycle began a long op, and stall counts.
    bit started   = 1'b0;
    bit second_hi = 1'b0;
    int cnt16     = 0;
    int cnt3      = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) bus16 ();
    hazard_ctrl_if #(.CNT_W(3))  bus3 ();

    assign bus16.Match_1E_M   = m1em;  assign bus3.Match_1E_M   = m1em;
    assign bus16.Match_1E_W   = m1ew;  assign bus3.Match_1E_W   = m1ew;
    assign bus16.Match_2E_M   = m2em;  assign bus3.Match_2E_M   = m2em;
    assign bus16.Match_2E_W   = m2ew;  assign bus3.Match_2E_W   = m2ew;
    assign bus16.Match_12D_E  = m12de; assign bus3.Match_12D_E  = m12de;
    assign bus16.RegWriteM    = rwm;   assign bus3.RegWriteM    = rwm;
    assign bus16.RegWriteW    = rww;   assign bus3.RegWriteW    = rww;
    assign bus16.MemtoRegE    = mtr;   assign bus3.MemtoRegE    = mtr;
    assign bus16.LongE        = lng;   assign bus3.LongE        = lng;
    assign bus16.BranchTakenE = br;    assign bus3.BranchTakenE = br;
    assign bus16.PCWrPendingF = pcw;   assign bus3.PCWrPendingF = pcw;
    assign bus16.PCSrcW       = pcsw;  assign bus3.PCSrcW       = pcsw;

    hazard_ctrl #(.CNT_W(16)) u_dut16 (.clk(clk), .reset(reset), .hz(bus16));
    hazard_ctrl #(.CNT_W(3))  u_dut3  (.clk(clk), .reset(reset), .hz(bus3));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int fwd(input logic mm, input logic wm, input logic mw, input logic ww);
        if (reset) return 0;
        if (mm && wm) return 2;      // Memory result is newest
        if (mw && ww) return 1;
        return 0;
    endfunction

    function automatic bit long_first();
        return !second_hi && lng && !br;
    endfunction

    function automatic bit exp_stall_d();
        return !reset && ((m12de && mtr) || long_first());
    endfunction

    task automatic check_set(input string t, input logic [1:0] fa, input logic [1:0] fb,
                             input logic sf, input logic sd, input logic se,
                             input logic fd, input logic fe, input logic lp,
                             input int cnt, input int ecnt);
        bit load_use;
        load_use = m12de && mtr;
        chk({t, ".ForwardAE"}, fa, fwd(m1em, rwm, m1ew, rww));
        chk({t, ".ForwardBE"}, fb, fwd(m2em, rwm, m2ew, rww));
        chk({t, ".StallF"}, sf, !reset && (load_use || pcw || long_first()));
        chk({t, ".StallD"}, sd, exp_stall_d());
        chk({t, ".StallE"}, se, !reset && long_first());
        chk({t, ".FlushD"}, fd, reset || pcw || pcsw || br);
        chk({t, ".FlushE"}, fe, reset || (!long_first() && (load_use || br)));
        chk({t, ".LongPhaseE"}, lp, !reset && second_hi);
        chk({t, ".StallCount"}, cnt, ecnt);
    endtask

    always @(posedge clk) begin
        started <= 1'b1;
        if (reset) begin
            second_hi <= 1'b0;
            cnt16     <= 0;
            cnt3      <= 0;
        end else begin
            second_hi <= long_first();
            if (exp_stall_d()) begin
                cnt16 <= (cnt16 < 65535) ? cnt16 + 1 : cnt16;
                cnt3  <= (cnt3 < 7) ? cnt3 + 1 : cnt3;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check_set("d16", bus16.ForwardAE, bus16.ForwardBE, bus16.StallF, bus16.StallD,
                      bus16.StallE, bus16.FlushD, bus16.FlushE, bus16.LongPhaseE,
                      int'(bus16.StallCount), cnt16);
            check_set("d3", bus3.ForwardAE, bus3.ForwardBE, bus3.StallF, bus3.StallD,
                      bus3.StallE, bus3.FlushD, bus3.FlushE, bus3.LongPhaseE,
                      int'(bus3.StallCount), cnt3);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        {m1em, m1ew, m2em, m2ew, m12de, rwm, rww, mtr, lng, br, pcw, pcsw} = '0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Post-reset idle state
        settle();
        chk("lit.reset.stalls", {bus16.StallF, bus16.StallD, bus16.StallE}, 0);
        chk("lit.reset.flushes", {bus16.FlushD, bus16.FlushE}, 0);
        chk("lit.reset.count", int'(bus16.StallCount), 0);
        chk("lit.reset.longphase", bus16.LongPhaseE, 0);
        chk("lit.reset.fwd", {bus16.ForwardAE, bus16.ForwardBE}, 0);

        // Forwarding priority, operand A then B
        next(); m1em = 1; m1ew = 1; rwm = 1; rww = 1;
        settle(); chk("lit.fwdA.mem", bus16.ForwardAE, 2);
        next(); rwm = 0;
        settle(); chk("lit.fwdA.wb", bus16.ForwardAE, 1);
        next(); rww = 0;
        settle(); chk("lit.fwdA.rf", bus16.ForwardAE, 0);
        next(); clear_inputs(); m2em = 1; m2ew = 1; rwm = 1; rww = 1;
        settle(); chk("lit.fwdB.mem", bus16.ForwardBE, 2);
        next(); rwm = 0;
        settle(); chk("lit.fwdB.wb", bus16.ForwardBE, 1);
        next(); rww = 0;
        settle(); chk("lit.fwdB.rf", bus16.ForwardBE, 0);

        // Load-use: one-cycle stall
        next(); clear_inputs(); m12de = 1; mtr = 1;
        settle(); chk("lit.ldr.stalls", {bus16.StallF, bus16.StallD, bus16.FlushE}, 3'b111);
        chk("lit.ldr.count0", int'(bus16.StallCount), 0);
        next(); clear_inputs();
        settle(); chk("lit.ldr.count1", int'(bus16.StallCount), 1);

        // Long multiply: lo word held, then hi word
        next(); lng = 1;
        settle(); chk("lit.long1.stalls", {bus16.StallF, bus16.StallD, bus16.StallE}, 3'b111);
        chk("lit.long1.flushE", bus16.FlushE, 0);
        chk("lit.long1.phase", bus16.LongPhaseE, 0);
        next();
        settle(); chk("lit.long2.phase", bus16.LongPhaseE, 1);
        chk("lit.long2.stalls", {bus16.StallF, bus16.StallD, bus16.StallE}, 0);
        next(); lng = 0;
        settle(); chk("lit.long3.phase", bus16.LongPhaseE, 0);
        chk("lit.long3.count", int'(bus16.StallCount), 2);

        // Branch beats long op
        next(); lng = 1; br = 1;
        settle(); chk("lit.br.flushes", {bus16.FlushD, bus16.FlushE}, 2'b11);
        chk("lit.br.stallE", bus16.StallE, 0);
        next(); clear_inputs();
        settle(); chk("lit.br.phase", bus16.LongPhaseE, 0);

        // Reset while in hi-word phase
        next(); lng = 1;
        next(); reset = 1;
        settle(); chk("lit.rstHi.phase", bus16.LongPhaseE, 0);
        chk("lit.rstHi.flushD", bus16.FlushD, 1);
        next(); reset = 0; lng = 0;
        settle(); chk("lit.rstHi.idle", bus16.LongPhaseE, 0);
        chk("lit.rstHi.count", int'(bus16.StallCount), 0);

        // Saturation: ten consecutive stall cycles
        next(); m12de = 1; mtr = 1;
        repeat (9) next();
        next(); clear_inputs();
        settle(); chk("lit.sat.cnt3", int'(bus3.StallCount), 7);
        chk("lit.sat.cnt16", int'(bus16.StallCount), 10);

        // PC write pending alone
        next(); pcw = 1;
        settle(); chk("lit.pcw.sig", {bus16.StallF, bus16.FlushD, bus16.StallD}, 3'b110);
        next(); pcw = 0; pcsw = 1;
        settle(); chk("lit.pcw.cnt3", int'(bus3.StallCount), 7);
        chk("lit.pcw.cnt16", int'(bus16.StallCount), 10);

        // Sweep forwarding combinations for model-checked coverage
        for (int v = 0; v < 32; v++) begin
            next();
            {m1em, m1ew, rwm, rww, m2em} = v[4:0];
            m2ew = ~v[0];
            pcsw = v[2];
        end
        next(); clear_inputs();
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
